// File: rtl/usb_trigger_generator_pkg.sv
// Shared definitions for the USB trigger generator.
//   state_e      : FSM state encoding (IDLE, DELAY, PULSE, GAP, DONE)
//   pMISSED_MAX  : saturation value of the missed-match counter
//   is_busy()    : true for the states that make up an active sequence
package usb_trigger_generator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DELAY = 3'd1,
    ST_PULSE = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [7:0] pMISSED_MAX = 8'hFF;

  function automatic logic is_busy(input state_e s);
    return (s == ST_DELAY) || (s == ST_PULSE) || (s == ST_GAP);
  endfunction

endpackage

// File: rtl/usb_trigger_generator_counter.sv
// trig_down_counter: loadable down-counter used for the delay, the shared
// width/gap timer and the remaining pulse count.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (has priority over dec)
//   load_val   : value to load
//   dec        : decrement by one (held at 0 if already 0)
//   zero       : the counter holds 1, so this decrement takes it to zero;
//                the FSM reloads or leaves on that cycle, so the flag is
//                high for a single cycle per load
module trig_down_counter #(
  parameter int pWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [pWIDTH-1:0] load_val,
  input  logic              dec,
  output logic              zero
);

  logic [pWIDTH-1:0] cnt_q;
  logic [pWIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - pWIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == pWIDTH'(1));

endmodule

// File: rtl/usb_trigger_generator.sv
// usb_trigger_generator: turns an accepted match pulse into a programmable
// trigger train (delay, then N pulses of set width separated by set gap).
//   trigger_clk, reset_n : clock, asynchronous active-low reset
//   I_arm                : arm level (already synchronised)
//   I_match              : single-cycle match pulse
//   I_delay/I_width/I_gap/I_count : sequence settings, latched on acceptance
//   O_trigger            : trigger output, straight from a flop
//   O_armed              : IDLE and armed (combinational)
//   O_busy               : sequence in progress
//   O_done               : sticky completion flag until disarm
//   O_missed             : saturating count of matches ignored while busy/done
module usb_trigger_generator
  import usb_trigger_generator_pkg::*;
#(
  parameter int pDELAY_WIDTH = 20,
  parameter int pPULSE_WIDTH = 17,
  parameter int pCOUNT_WIDTH = 4
) (
  input  logic                    trigger_clk,
  input  logic                    reset_n,
  input  logic                    I_arm,
  input  logic                    I_match,
  input  logic [pDELAY_WIDTH-1:0] I_delay,
  input  logic [pPULSE_WIDTH-1:0] I_width,
  input  logic [pPULSE_WIDTH-1:0] I_gap,
  input  logic [pCOUNT_WIDTH-1:0] I_count,
  output logic                    O_trigger,
  output logic                    O_armed,
  output logic                    O_busy,
  output logic                    O_done,
  output logic [7:0]              O_missed
);

  state_e                  state_q, state_d;
  logic [pPULSE_WIDTH-1:0] width_q, width_d;
  logic [pPULSE_WIDTH-1:0] gap_q, gap_d;
  logic [7:0]              missed_q, missed_d;
  logic                    trigger_q, busy_q, done_q;

  // Zero-valued width, gap and count settings behave as 1.
  logic [pPULSE_WIDTH-1:0] width_in, gap_in;
  logic [pCOUNT_WIDTH-1:0] count_in;
  assign width_in = (I_width == '0) ? pPULSE_WIDTH'(1) : I_width;
  assign gap_in   = (I_gap   == '0) ? pPULSE_WIDTH'(1) : I_gap;
  assign count_in = (I_count == '0) ? pCOUNT_WIDTH'(1) : I_count;

  logic                    dly_load, dly_dec, dly_zero;
  logic                    tmr_load, tmr_dec, tmr_zero;
  logic [pPULSE_WIDTH-1:0] tmr_val;
  logic                    cnt_load, cnt_dec, cnt_zero;

  trig_down_counter #(.pWIDTH(pDELAY_WIDTH)) u_delay (
    .clk(trigger_clk), .rst_n(reset_n), .load(dly_load), .load_val(I_delay),
    .dec(dly_dec), .zero(dly_zero)
  );

  // One timer serves both the high (width) and low (gap) phases.
  trig_down_counter #(.pWIDTH(pPULSE_WIDTH)) u_timer (
    .clk(trigger_clk), .rst_n(reset_n), .load(tmr_load), .load_val(tmr_val),
    .dec(tmr_dec), .zero(tmr_zero)
  );

  trig_down_counter #(.pWIDTH(pCOUNT_WIDTH)) u_count (
    .clk(trigger_clk), .rst_n(reset_n), .load(cnt_load), .load_val(count_in),
    .dec(cnt_dec), .zero(cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    gap_d    = gap_q;
    missed_d = missed_q;
    dly_load = 1'b0;
    dly_dec  = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = width_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (I_arm && I_match) begin
          width_d  = width_in;
          gap_d    = gap_in;
          dly_load = 1'b1;
          cnt_load = 1'b1;
          missed_d = '0;
          if (I_delay != '0) begin
            state_d = ST_DELAY;
          end else begin
            // No delay: the first pulse starts next cycle, so the timer
            // takes the live (mapped) width rather than the latched copy.
            state_d  = ST_PULSE;
            tmr_load = 1'b1;
            tmr_val  = width_in;
          end
        end
      end
      ST_DELAY: begin
        if (dly_zero) begin
          state_d  = ST_PULSE;
          tmr_load = 1'b1;
        end else begin
          dly_dec = 1'b1;
        end
      end
      ST_PULSE: begin
        if (tmr_zero) begin
          if (cnt_zero) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_GAP;
            cnt_dec  = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = gap_q;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_GAP: begin
        if (tmr_zero) begin
          state_d  = ST_PULSE;
          tmr_load = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_DONE: begin
        if (!I_arm) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Disarm during a sequence overrides every other transition, including
    // the end of the last pulse, so DONE is never reached on an abort.
    if (is_busy(state_q) && !I_arm) begin
      state_d = ST_IDLE;
    end

    if ((state_q != ST_IDLE) && I_match && (missed_q != pMISSED_MAX)) begin
      missed_d = missed_q + 8'd1;
    end
  end

  always_ff @(posedge trigger_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      width_q   <= '0;
      gap_q     <= '0;
      missed_q  <= '0;
      trigger_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      width_q   <= width_d;
      gap_q     <= gap_d;
      missed_q  <= missed_d;
      // Outputs are registered from the next state so they line up with it.
      trigger_q <= (state_d == ST_PULSE);
      busy_q    <= is_busy(state_d);
      done_q    <= (state_d == ST_DONE);
    end
  end

  assign O_trigger = trigger_q;
  assign O_busy    = busy_q;
  assign O_done    = done_q;
  assign O_missed  = missed_q;
  // Held low while in reset so every output reads 0 then.
  assign O_armed   = reset_n && (state_q == ST_IDLE) && I_arm;

endmodule

// File: tb/tb_usb_trigger_generator.sv
module tb_usb_trigger_generator;

  logic        trigger_clk = 1'b0;
  logic        reset_n;
  logic        I_arm;
  logic        I_match;
  logic [19:0] I_delay;
  logic [16:0] I_width;
  logic [16:0] I_gap;
  logic [3:0]  I_count;
  logic        O_trigger;
  logic        O_armed;
  logic        O_busy;
  logic        O_done;
  logic [7:0]  O_missed;

  int checks = 0;
  int errors = 0;

  usb_trigger_generator #(
    .pDELAY_WIDTH(20), .pPULSE_WIDTH(17), .pCOUNT_WIDTH(4)
  ) dut (
    .trigger_clk(trigger_clk), .reset_n(reset_n), .I_arm(I_arm),
    .I_match(I_match), .I_delay(I_delay), .I_width(I_width), .I_gap(I_gap),
    .I_count(I_count), .O_trigger(O_trigger), .O_armed(O_armed),
    .O_busy(O_busy), .O_done(O_done), .O_missed(O_missed)
  );

  always #5 trigger_clk = ~trigger_clk;

  // Reference timeline for a match accepted in cycle 0.
  function automatic logic exp_trig(input int k, input int d, input int w,
                                    input int g, input int n);
    int p;
    if (k < d + 1) return 1'b0;
    p = k - (d + 1);
    return ((p / (w + g)) < n) && ((p % (w + g)) < w);
  endfunction

  // Arms are assumed high; runs one full sequence and checks every cycle.
  task automatic run_seq(input int d, input int w, input int g, input int n,
                         input string tag);
    int we, ge, ne, total;
    logic et, eb, ed;
    we = (w == 0) ? 1 : w;
    ge = (g == 0) ? 1 : g;
    ne = (n == 0) ? 1 : n;
    total = d + ne * we + (ne - 1) * ge;
    I_delay = 20'(d); I_width = 17'(w); I_gap = 17'(g); I_count = 4'(n);
    checks++;
    if (O_armed !== 1'b1) begin
      errors++; $display("FAIL %s armed_before got %b want 1", tag, O_armed);
    end
    I_match = 1'b1;
    @(negedge trigger_clk);
    I_match = 1'b0;
    // Scramble settings: only latched copies may matter now.
    I_delay = 20'd3; I_width = 17'd7; I_gap = 17'd0; I_count = 4'd9;
    for (int k = 1; k <= total + 2; k++) begin
      et = exp_trig(k, d, we, ge, ne);
      eb = (k <= total);
      ed = (k > total);
      checks++;
      if ({O_trigger, O_busy, O_done} !== {et, eb, ed}) begin
        errors++;
        $display("FAIL %s cycle %0d trig/busy/done got %b%b%b want %b%b%b",
                 tag, k, O_trigger, O_busy, O_done, et, eb, ed);
      end
      if (k < total + 2) @(negedge trigger_clk);
    end
    I_arm = 1'b0;
    @(negedge trigger_clk);
    checks++;
    if ({O_done, O_armed, O_busy} !== 3'b000) begin
      errors++; $display("FAIL %s disarm done/armed/busy got %b%b%b want 000",
                         tag, O_done, O_armed, O_busy);
    end
    I_arm = 1'b1;
    @(negedge trigger_clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; I_arm = 1'b0; I_match = 1'b0;
    I_delay = '0; I_width = '0; I_gap = '0; I_count = '0;
    #1;
    checks++;
    if ({O_trigger, O_armed, O_busy, O_done, O_missed} !== 12'h000) begin
      errors++; $display("FAIL reset outputs got %b%b%b%b %h want all 0",
                         O_trigger, O_armed, O_busy, O_done, O_missed);
    end
    repeat (2) @(negedge trigger_clk);
    reset_n = 1'b1;
    @(negedge trigger_clk);
    I_arm = 1'b1;
    #1;
    checks++;
    if (O_armed !== 1'b1) begin
      errors++; $display("FAIL reset_armed got %b want 1", O_armed);
    end
    @(negedge trigger_clk);
  endtask

  task automatic test_basic();
    run_seq(5, 3, 1, 1, "basic");
  endtask

  task automatic test_zero_settings();
    run_seq(0, 0, 0, 0, "zero");
  endtask

  task automatic test_train();
    run_seq(2, 2, 3, 3, "train");
  endtask

  task automatic test_dropped();
    // Arm falling together with a match in IDLE: nothing accepted.
    I_arm = 1'b0; I_match = 1'b1;
    @(negedge trigger_clk);
    I_match = 1'b0;
    checks++;
    if ({O_busy, O_trigger, O_missed} !== 10'h000) begin
      errors++; $display("FAIL dropped busy/trig/missed got %b%b %0d want 0 0 0",
                         O_busy, O_trigger, O_missed);
    end
    I_arm = 1'b1;
    @(negedge trigger_clk);
  endtask

  task automatic test_missed();
    I_delay = 20'd5; I_width = 17'd3; I_gap = 17'd1; I_count = 4'd1;
    I_match = 1'b1;
    for (int i = 1; i <= 301; i++) begin
      @(negedge trigger_clk);
      if (i == 11) begin
        checks++;
        if (O_missed !== 8'd10) begin
          errors++; $display("FAIL missed_10 got %0d want 10", O_missed);
        end
      end
    end
    checks++;
    if ({O_missed, O_done} !== {8'd255, 1'b1}) begin
      errors++; $display("FAIL missed_sat got %0d done %b want 255 1",
                         O_missed, O_done);
    end
    I_match = 1'b0; I_arm = 1'b0;
    @(negedge trigger_clk);
    checks++;
    if (O_missed !== 8'd255) begin
      errors++; $display("FAIL missed_hold got %0d want 255", O_missed);
    end
    I_arm = 1'b1;
    @(negedge trigger_clk);
    I_match = 1'b1;
    @(negedge trigger_clk);
    I_match = 1'b0;
    checks++;
    if ({O_missed, O_busy} !== {8'd0, 1'b1}) begin
      errors++; $display("FAIL missed_clear got %0d busy %b want 0 1",
                         O_missed, O_busy);
    end
    repeat (12) @(negedge trigger_clk);
    I_arm = 1'b0;
    @(negedge trigger_clk);
    I_arm = 1'b1;
    @(negedge trigger_clk);
  endtask

  task automatic test_abort();
    // D=1 W=4 G=2 N=3: second pulse occupies cycles 8-11.
    I_delay = 20'd1; I_width = 17'd4; I_gap = 17'd2; I_count = 4'd3;
    I_match = 1'b1;
    @(negedge trigger_clk);
    I_match = 1'b0;
    repeat (8) @(negedge trigger_clk);
    checks++;
    if (O_trigger !== 1'b1) begin
      errors++; $display("FAIL abort_pre trig got %b want 1", O_trigger);
    end
    I_arm = 1'b0;
    for (int k = 10; k <= 12; k++) begin
      @(negedge trigger_clk);
      checks++;
      if ({O_trigger, O_busy, O_done, O_armed} !== 4'b0000) begin
        errors++; $display("FAIL abort cycle %0d trig/busy/done/armed got %b%b%b%b want 0000",
                           k, O_trigger, O_busy, O_done, O_armed);
      end
    end
    I_arm = 1'b1;
    @(negedge trigger_clk);
    run_seq(1, 4, 2, 3, "rearm");
    // Abort in the final cycle of the last pulse: no DONE.
    I_delay = 20'd0; I_width = 17'd2; I_gap = 17'd1; I_count = 4'd1;
    I_match = 1'b1;
    @(negedge trigger_clk);
    I_match = 1'b0;
    @(negedge trigger_clk);
    I_arm = 1'b0;
    @(negedge trigger_clk);
    checks++;
    if ({O_trigger, O_busy, O_done} !== 3'b000) begin
      errors++; $display("FAIL abort_last trig/busy/done got %b%b%b want 000",
                         O_trigger, O_busy, O_done);
    end
    I_arm = 1'b1;
    @(negedge trigger_clk);
  endtask

  task automatic test_async_reset();
    I_delay = 20'd0; I_width = 17'd10; I_gap = 17'd1; I_count = 4'd1;
    I_match = 1'b1;
    @(negedge trigger_clk);
    I_match = 1'b0;
    repeat (3) @(negedge trigger_clk);
    checks++;
    if (O_trigger !== 1'b1) begin
      errors++; $display("FAIL rst_pre trig got %b want 1", O_trigger);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({O_trigger, O_armed, O_busy, O_done, O_missed} !== 12'h000) begin
      errors++; $display("FAIL rst_async outputs got %b%b%b%b %h want all 0",
                         O_trigger, O_armed, O_busy, O_done, O_missed);
    end
    @(negedge trigger_clk);
    reset_n = 1'b1;
    @(negedge trigger_clk);
    run_seq(5, 3, 1, 1, "after_rst");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_settings();
    test_train();
    test_dropped();
    test_missed();
    test_abort();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached without finishing");
    $fatal(1);
  end

endmodule
